// File: rtl/taxi_axis_stat_sink_if.sv
// AXI4-Stream bundle shared by sources, sinks and monitors.
// src drives the stream, snk consumes it and returns tready.
interface taxi_axis_if #(
    parameter int DATA_W  = 64,
    parameter bit KEEP_EN = 1'b1,
    parameter int KEEP_W  = (DATA_W + 7) / 8,
    parameter int ID_W    = 8,
    parameter int DEST_W  = 8,
    parameter int USER_W  = 1
) ();
    logic [DATA_W-1:0] tdata;
    logic [KEEP_W-1:0] tkeep;
    logic [KEEP_W-1:0] tstrb;
    logic              tvalid;
    logic              tready;
    logic              tlast;
    logic [ID_W-1:0]   tid;
    logic [DEST_W-1:0] tdest;
    logic [USER_W-1:0] tuser;

    modport src (
        output tdata, tkeep, tstrb, tvalid, tlast, tid, tdest, tuser,
        input  tready
    );

    modport snk (
        input  tdata, tkeep, tstrb, tvalid, tlast, tid, tdest, tuser,
        output tready
    );
endinterface

// File: rtl/taxi_axis_stat_sink.sv
// AXI4-Stream statistics sink: discards data, counts frames/bytes/errors.
// Define TAXI_AXIS_STAT_SINK_THROTTLE_EN to gate tready with an LFSR duty cycle.
module taxi_axis_stat_sink #(
    parameter int          CNT_W     = 32,
    parameter int          LEN_W     = 16,
    parameter logic [31:0] LFSR_SEED = 32'hACE1_2468
) (
    input  logic             clk,
    input  logic             rst_n,
    taxi_axis_if.snk         s_axis,
    input  logic             enable,
    input  logic             clear,
    input  logic [7:0]       throttle,
    output logic [CNT_W-1:0] frame_cnt,
    output logic [CNT_W-1:0] byte_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic             frame_done,
    output logic [LEN_W-1:0] frame_len,
    output logic             frame_ovf,
    output logic             busy
);
    localparam int KEEP_W = s_axis.KEEP_W;
    localparam bit KEEP_EN = s_axis.KEEP_EN;
    localparam int BB_W = $clog2(KEEP_W + 1);
    localparam int SUM_W = ((LEN_W > BB_W) ? LEN_W : BB_W) + 1;
    localparam logic [SUM_W-1:0] LEN_MAX = SUM_W'({LEN_W{1'b1}});

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_FRAME = 1'b1;

    logic [0:0]       state;
    logic [LEN_W-1:0] len_acc;
    logic             ovf_acc;
    logic             tready_r;
    logic             ready_next;
    logic             hs;
    logic [BB_W-1:0]  beat_bytes;
    logic [SUM_W-1:0] len_sum;
    logic [LEN_W-1:0] len_next;
    logic             ovf_next;
    logic             unused_sigs;

    assign s_axis.tready = tready_r;
    assign hs            = s_axis.tvalid && tready_r;
    assign busy          = (state == ST_FRAME);
    assign unused_sigs   = ^{s_axis.tdata, s_axis.tstrb, s_axis.tid, s_axis.tdest,
                             s_axis.tuser, s_axis.tkeep, throttle};

    always_comb begin
        beat_bytes = '0;
        if (KEEP_EN) begin
            for (int unsigned i = 0; i < KEEP_W; i++) begin
                beat_bytes = beat_bytes + BB_W'(s_axis.tkeep[i]);
            end
        end else begin
            beat_bytes = BB_W'(KEEP_W);
        end
    end

    // In IDLE the accepted beat starts a new frame, so the old accumulator is ignored.
    always_comb begin
        len_sum  = ((state == ST_FRAME) ? SUM_W'(len_acc) : '0) + SUM_W'(beat_bytes);
        len_next = (len_sum > LEN_MAX) ? '1 : len_sum[LEN_W-1:0];
        ovf_next = ((state == ST_FRAME) && ovf_acc) || (len_sum > LEN_MAX);
    end

`ifdef TAXI_AXIS_STAT_SINK_THROTTLE_EN
    logic [31:0] lfsr;

    // Galois form of x^32 + x^22 + x^2 + x + 1, shifting right.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr <= LFSR_SEED;
        end else begin
            lfsr <= {1'b0, lfsr[31:1]} ^ (lfsr[0] ? 32'h8020_0003 : '0);
        end
    end

    assign ready_next = enable && (lfsr[7:0] >= throttle);
`else
    assign ready_next = enable;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tready_r <= 1'b0;
        end else begin
            tready_r <= ready_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            len_acc    <= '0;
            ovf_acc    <= 1'b0;
            frame_done <= 1'b0;
            frame_len  <= '0;
            frame_ovf  <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (hs) begin
                if (s_axis.tlast) begin
                    state      <= ST_IDLE;
                    frame_done <= 1'b1;
                    frame_len  <= len_next;
                    frame_ovf  <= ovf_next;
                end else begin
                    state   <= ST_FRAME;
                    len_acc <= len_next;
                    ovf_acc <= ovf_next;
                end
            end
        end
    end

    // clear takes priority over a coincident beat; only the counters are affected.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt <= '0;
            byte_cnt  <= '0;
            err_cnt   <= '0;
        end else if (clear) begin
            frame_cnt <= '0;
            byte_cnt  <= '0;
            err_cnt   <= '0;
        end else if (hs) begin
            byte_cnt <= byte_cnt + CNT_W'(beat_bytes);
            if (s_axis.tlast) begin
                frame_cnt <= frame_cnt + CNT_W'(1);
                err_cnt   <= err_cnt + CNT_W'(s_axis.tuser[0]);
            end
        end
    end
endmodule

// File: tb/tb_taxi_axis_stat_sink.sv
// Directed bench for taxi_axis_stat_sink; duty-cycle check only when
// TAXI_AXIS_STAT_SINK_THROTTLE_EN is defined.
module tb_taxi_axis_stat_sink;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable;
    logic       clear;
    logic [7:0] throttle;
    logic       tvalid;
    logic       tlast;
    logic [7:0] tkeep;
    logic [0:0] tuser;

    always #5 clk = ~clk;

    taxi_axis_if #(.DATA_W(64), .USER_W(1)) ax_a ();
    taxi_axis_if #(.DATA_W(64), .USER_W(1)) ax_b ();

    assign ax_a.tdata  = '0;
    assign ax_a.tkeep  = tkeep;
    assign ax_a.tstrb  = tkeep;
    assign ax_a.tvalid = tvalid;
    assign ax_a.tlast  = tlast;
    assign ax_a.tid    = '0;
    assign ax_a.tdest  = '0;
    assign ax_a.tuser  = tuser;
    assign ax_b.tdata  = '0;
    assign ax_b.tkeep  = tkeep;
    assign ax_b.tstrb  = tkeep;
    assign ax_b.tvalid = tvalid;
    assign ax_b.tlast  = tlast;
    assign ax_b.tid    = '0;
    assign ax_b.tdest  = '0;
    assign ax_b.tuser  = tuser;

    logic [31:0] a_fcnt, a_bcnt, a_ecnt;
    logic        a_done, a_ovf, a_busy;
    logic [15:0] a_len;
    logic [3:0]  b_fcnt, b_bcnt, b_ecnt;
    logic        b_done, b_ovf, b_busy;
    logic [3:0]  b_len;
    logic        ready_a;

    assign ready_a = ax_a.tready;

    taxi_axis_stat_sink #(.CNT_W(32), .LEN_W(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .s_axis(ax_a), .enable(enable), .clear(clear),
        .throttle(throttle), .frame_cnt(a_fcnt), .byte_cnt(a_bcnt), .err_cnt(a_ecnt),
        .frame_done(a_done), .frame_len(a_len), .frame_ovf(a_ovf), .busy(a_busy)
    );

    taxi_axis_stat_sink #(.CNT_W(4), .LEN_W(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .s_axis(ax_b), .enable(enable), .clear(clear),
        .throttle(throttle), .frame_cnt(b_fcnt), .byte_cnt(b_bcnt), .err_cnt(b_ecnt),
        .frame_done(b_done), .frame_len(b_len), .frame_ovf(b_ovf), .busy(b_busy)
    );

    int          checks   = 0;
    int          failures = 0;
    int unsigned cyc      = 0;
    int unsigned done_cnt = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (a_done) done_cnt <= done_cnt + 1;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One beat; waits (bounded) for tready, returns #1 after the handshake edge.
    task automatic beat(input logic [7:0] k, input logic l, input logic u, input logic c);
        int unsigned n = 0;
        @(negedge clk);
        tvalid = 1'b1; tkeep = k; tlast = l; tuser = u; clear = c;
        while (!ready_a && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            checks++;
            failures++;
            $display("FAIL beat_timeout: got no tready expected tready within 200 cycles");
        end
        @(posedge clk);
        #1;
        tvalid = 1'b0; tlast = 1'b0; tuser = 1'b0; clear = 1'b0;
    endtask

    typedef struct {
        int unsigned nbeats;
        logic [7:0]  last_keep;
        logic        user_last;
        logic        clr_last;
        logic [15:0] exp_len;
        logic [31:0] exp_fcnt;
        logic [31:0] exp_bcnt;
        logic [31:0] exp_ecnt;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int unsigned d0, t0, t1, n;

        vecs[0] = '{4, 8'h0F, 1'b0, 1'b0, 16'd28, 32'd1, 32'd28,  32'd0};
        vecs[1] = '{1, 8'h0F, 1'b0, 1'b0, 16'd4,  32'd2, 32'd32,  32'd0};
        vecs[2] = '{7, 8'h0F, 1'b0, 1'b0, 16'd52, 32'd3, 32'd84,  32'd0};
        vecs[3] = '{2, 8'hFF, 1'b1, 1'b0, 16'd16, 32'd4, 32'd100, 32'd1};
        vecs[4] = '{3, 8'h01, 1'b0, 1'b0, 16'd17, 32'd5, 32'd117, 32'd1};
        vecs[5] = '{2, 8'hFF, 1'b0, 1'b1, 16'd16, 32'd0, 32'd0,   32'd0};
        vecs[6] = '{1, 8'h0F, 1'b0, 1'b0, 16'd4,  32'd1, 32'd4,   32'd0};

        rst_n = 1'b0; enable = 1'b1; clear = 1'b0; throttle = 8'h00;
        tvalid = 1'b0; tlast = 1'b0; tkeep = 8'h00; tuser = 1'b0;
        #1;
        chk("rst_tready", 64'(ready_a), 64'd0);
        chk("rst_fcnt", 64'(a_fcnt), 64'd0);
        chk("rst_bcnt", 64'(a_bcnt), 64'd0);
        chk("rst_ecnt", 64'(a_ecnt), 64'd0);
        chk("rst_done", 64'(a_done), 64'd0);
        chk("rst_len", 64'(a_len), 64'd0);
        chk("rst_ovf", 64'(a_ovf), 64'd0);
        chk("rst_busy", 64'(a_busy), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tready_held", 64'(ready_a), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("tready_low_after_rst", 64'(ready_a), 64'd0);

        for (int v = 0; v < 7; v++) begin
            for (int unsigned b = 0; b < vecs[v].nbeats; b++) begin
                if (b == vecs[v].nbeats - 1) begin
                    beat(vecs[v].last_keep, 1'b1, vecs[v].user_last, vecs[v].clr_last);
                end else begin
                    beat(8'hFF, 1'b0, 1'b0, 1'b0);
                    if (b == 0) chk("vec_busy_mid", 64'(a_busy), 64'd1);
                end
            end
            chk("vec_done", 64'(a_done), 64'd1);
            chk("vec_len", 64'(a_len), 64'(vecs[v].exp_len));
            chk("vec_ovf", 64'(a_ovf), 64'd0);
            chk("vec_fcnt", 64'(a_fcnt), 64'(vecs[v].exp_fcnt));
            chk("vec_bcnt", 64'(a_bcnt), 64'(vecs[v].exp_bcnt));
            chk("vec_ecnt", 64'(a_ecnt), 64'(vecs[v].exp_ecnt));
            chk("vec_busy_end", 64'(a_busy), 64'd0);
            @(posedge clk);
            #1;
            chk("vec_done_pulse", 64'(a_done), 64'd0);
        end

        // enable dropped mid-frame: FSM and length held, no beats accepted
        beat(8'hFF, 1'b0, 1'b0, 1'b0);
        beat(8'hFF, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        tvalid = 1'b1; tlast = 1'b1; tkeep = 8'h0F;
        repeat (3) @(negedge clk);
        chk("en_tready_low", 64'(ready_a), 64'd0);
        chk("en_busy_held", 64'(a_busy), 64'd1);
        chk("en_bcnt_held", 64'(a_bcnt), 64'd20);
        tvalid = 1'b0; tlast = 1'b0;
        enable = 1'b1;
        beat(8'h0F, 1'b1, 1'b0, 1'b0);
        chk("en_len", 64'(a_len), 64'd20);
        chk("en_fcnt", 64'(a_fcnt), 64'd2);
        chk("en_bcnt", 64'(a_bcnt), 64'd24);

        // reset mid-frame discards the partial frame
        beat(8'hFF, 1'b0, 1'b0, 1'b0);
        beat(8'hFF, 1'b0, 1'b0, 1'b0);
        d0 = done_cnt;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mrst_busy", 64'(a_busy), 64'd0);
        chk("mrst_fcnt", 64'(a_fcnt), 64'd0);
        chk("mrst_len", 64'(a_len), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        beat(8'hFF, 1'b0, 1'b0, 1'b0);
        beat(8'hFF, 1'b0, 1'b0, 1'b0);
        beat(8'hFF, 1'b1, 1'b0, 1'b0);
        chk("mrst_len_after", 64'(a_len), 64'd24);
        chk("mrst_fcnt_after", 64'(a_fcnt), 64'd1);
        chk("mrst_bcnt_after", 64'(a_bcnt), 64'd24);
        @(posedge clk);
        #1;
        chk("mrst_done_count", 64'(done_cnt - d0), 64'd1);

        // narrow instance: length saturation and counter wrap
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        beat(8'hFF, 1'b0, 1'b0, 1'b0);
        beat(8'hFF, 1'b0, 1'b0, 1'b0);
        beat(8'hFF, 1'b1, 1'b0, 1'b0);
        chk("sat_done", 64'(b_done), 64'd1);
        chk("sat_len", 64'(b_len), 64'd15);
        chk("sat_ovf", 64'(b_ovf), 64'd1);
        beat(8'h0F, 1'b1, 1'b0, 1'b0);
        chk("sat_next_len", 64'(b_len), 64'd4);
        chk("sat_next_ovf", 64'(b_ovf), 64'd0);

        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        chk("clr_b_fcnt", 64'(b_fcnt), 64'd0);
        beat(8'hFF, 1'b1, 1'b0, 1'b0);
        t0 = cyc;
        for (int i = 1; i < 17; i++) beat(8'hFF, 1'b1, 1'b0, 1'b0);
        t1 = cyc;
        chk("wrap_no_stall", 64'(t1 - t0), 64'd16);
        chk("wrap_fcnt", 64'(b_fcnt), 64'd1);
        chk("wrap_bcnt", 64'(b_bcnt), 64'd8);

        @(negedge clk);
        throttle = 8'h80;
        n = 0;
`ifdef TAXI_AXIS_STAT_SINK_THROTTLE_EN
        repeat (1000) begin
            @(posedge clk);
            #1;
            n += 32'(ready_a);
        end
        checks++;
        if (n < 400 || n > 600) begin
            failures++;
            $display("FAIL throttle_duty: got %0d ready cycles expected 400..600 of 1000", n);
        end
`else
        repeat (50) begin
            @(posedge clk);
            #1;
            n += 32'(ready_a);
        end
        chk("throttle_ignored", 64'(n), 64'd50);
`endif
        throttle = 8'h00;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got no finish expected finish before 2ms");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/taxi_axis_stat_sink.md
TAXI_AXIS_STAT_SINK -- requirements
Module: taxi_axis_stat_sink

Interface
REQ-001 SHALL have parameter CNT_W, default 32, statistics counter width.
REQ-002 SHALL have parameter LEN_W, default 16, per-frame byte-length width.
REQ-003 SHALL have parameter LFSR_SEED, default 32'hACE1_2468, throttle LFSR reset value (nonzero).
REQ-004 SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port s_axis  taxi_axis_if.snk  DATA_W/KEEP_W/USER_W from interface  AXI4-Stream input consumed and discarded.
REQ-007 SHALL have port enable  input  1  when low, tready held low.
REQ-008 SHALL have port clear  input  1  synchronous statistics clear pulse.
REQ-009 SHALL have port throttle  input  8  ready duty threshold (used only with throttle feature).
REQ-010 SHALL have port frame_cnt  output  CNT_W  completed frames.
REQ-011 SHALL have port byte_cnt  output  CNT_W  accepted bytes.
REQ-012 SHALL have port err_cnt  output  CNT_W  completed frames with tuser[0]=1 on the tlast beat.
REQ-013 SHALL have port frame_done  output  1  one-cycle pulse per completed frame.
REQ-014 SHALL have port frame_len  output  LEN_W  byte length of last completed frame, valid with frame_done.
REQ-015 SHALL have port frame_ovf  output  1  last completed frame exceeded 2^LEN_W-1 bytes, valid with frame_done.
REQ-016 SHALL have port busy  output  1  high while in state FRAME.

Function
REQ-017 Beat accepted SHALL mean tvalid && tready on a clk edge; tdata, tid, tdest, tstrb ignored.
REQ-018 Beat bytes SHALL be popcount(tkeep) when interface KEEP_EN=1, else KEEP_W.
REQ-019 FSM SHALL have states IDLE and FRAME; IDLE->FRAME on accepted beat with tlast=0; FRAME->IDLE on accepted beat with tlast=1; single-beat frame (tlast=1 in IDLE) stays IDLE and completes.
REQ-020 Frame length accumulator SHALL sum beat bytes, saturating at 2^LEN_W-1 and setting a sticky oversize bit, both cleared at frame start.
REQ-021 On completing beat, frame_done, frame_len (including that beat) and frame_ovf SHALL be registered, visible exactly 1 cycle after the handshake edge.
REQ-022 frame_cnt, byte_cnt, err_cnt SHALL update 1 cycle after the handshake and wrap modulo 2^CNT_W.
REQ-023 clear SHALL zero all three counters next cycle; clear coincident with a handshake SHALL win (beat not counted) but FSM, frame_len and frame_done still update.
REQ-024 tready SHALL be a register output: enable && throttle gate, with no combinational path from tvalid.
REQ-025 enable falling mid-frame SHALL hold FSM in FRAME and preserve the accumulated length until resumed.

Reset
REQ-026 On rst_n low, asynchronously: FSM=IDLE, tready=0, all counters=0, frame_done=0, frame_len=0, frame_ovf=0, busy=0, LFSR=LFSR_SEED.
REQ-027 Reset mid-frame SHALL discard the partial frame; no frame_done issued for it.
REQ-028 tready SHALL stay low for the first cycle after rst_n deasserts.

Configuration
REQ-029 With TAXI_AXIS_STAT_SINK_THROTTLE_EN defined, a 32-bit Galois LFSR (taps 32,22,2,1) SHALL advance every cycle and next tready = enable && (lfsr[7:0] >= throttle); throttle=0 means always ready.
REQ-030 Without TAXI_AXIS_STAT_SINK_THROTTLE_EN, no LFSR SHALL exist, throttle SHALL be ignored, and next tready = enable.

Verification
REQ-031 Three frames of 4, 1, 7 beats, 64-bit data, all keep=8'hFF, last keep=8'h0F -> frame_len 28, 4, 52; frame_cnt=3; byte_cnt=84.
REQ-032 Frame with tuser[0]=1 on tlast beat, then clean frame -> err_cnt=1, frame_cnt=2.
REQ-033 CNT_W=4, 17 single-beat frames -> frame_cnt=1 (wrap), no stall.
REQ-034 LEN_W=4, 3 beats keep=8'hFF -> frame_len=15, frame_ovf=1; next 1-beat frame frame_ovf=0.
REQ-035 clear asserted on tlast handshake of frame 2 -> frame_cnt=0, frame_done pulses, frame_len correct.
REQ-036 rst_n pulsed low mid-frame after 2 beats, then one 3-beat frame -> only one frame_done, frame_len=24; with throttle=8'h80 (THROTTLE_EN) tready duty ~50% over 1000 cycles.
